codec_init_sequencer: RTL and testbench

Table-driven, parametrised CODEC initialisation sequencer, the successor to the single-probe init unit in the codec unit. Out of reset, and on each `start` request, it probes the CODEC with a read, then writes each entry of an N-entry register table through the I2C controller's rd/wr handshake. Each step has a timeout and a retry count. Optionally, each write is read back and checked. It drives `codec_is_alive`, `init_done` and `init_error` to the rest of the design.

---
 rtl/codec_init_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : codec_init_sequencer
// Brief    : Table-driven CODEC bring-up: probe read, then write every table
//            entry through the I2C controller with per-step timeout and retry.
//            Optional read-back check of each write: CODEC_INIT_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module codec_init_sequencer #(
  parameter int NUM_ENTRIES    = 8,
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [NUM_ENTRIES*(ADDR_W+DATA_W)-1:0] init_table,
  output logic                                   codec_rd_en,
  output logic                                   codec_wr_en,
  output logic [ADDR_W-1:0]                      codec_reg_addr,
  output logic [DATA_W-1:0]                      codec_data_out,
  input  logic [DATA_W-1:0]                      codec_data_in,
  input  logic                                   codec_data_in_valid,
  input  logic                                   controller_busy,
  output logic                                   codec_is_alive,
  output logic                                   init_done,
  output logic                                   init_error,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]       error_index,
  output logic                                   busy
);

  localparam int C_ENTRY_W = ADDR_W + DATA_W;
  localparam int C_IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int C_ERR_W   = $clog2(NUM_ENTRIES + 1);
  localparam int C_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int C_RTY_W   = 4;

  // The re-issue cycle closes the window, so retries land TIMEOUT_CYCLES apart.
  localparam logic [C_TO_W-1:0]  C_TO_LAST  = C_TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_ENTRIES - 1);
  localparam logic [C_RTY_W-1:0] C_RTY_MAX  = C_RTY_W'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PROBE_RD   = 4'd1,
    PROBE_WAIT = 4'd2,
    WR_ISSUE   = 4'd3,
    WR_WAIT    = 4'd4,
    VRFY_RD    = 4'd5,
    VRFY_WAIT  = 4'd6,
    NEXT       = 4'd7,
    DONE       = 4'd8,
    ERROR      = 4'd9
  } state_t;

  state_t               r_state, w_state_nxt, w_retry_state;
  logic [C_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [C_RTY_W-1:0]   r_retry, w_retry_nxt;
  logic [C_TO_W-1:0]    r_tcnt, w_tcnt_nxt;
  logic                 r_seen_busy, w_seen_nxt;
  logic                 r_rd_en, w_rd_en_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
  logic [DATA_W-1:0]    r_data, w_data_nxt;
  logic                 r_alive, w_alive_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_error, w_error_nxt;
  logic [C_ERR_W-1:0]   r_err_idx, w_err_idx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_fail;
  logic                 w_timeout;

  logic [C_ENTRY_W-1:0] w_table [NUM_ENTRIES];
  logic [ADDR_W-1:0]    w_entry_addr;
  logic [DATA_W-1:0]    w_entry_data;
  logic [ADDR_W-1:0]    w_probe_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_unpack
      assign w_table[gi] = init_table[gi*C_ENTRY_W +: C_ENTRY_W];
    end
  endgenerate

  assign w_entry_addr = w_table[r_idx][C_ENTRY_W-1 -: ADDR_W];
  assign w_entry_data = w_table[r_idx][DATA_W-1:0];
  assign w_probe_addr = w_table[0][C_ENTRY_W-1 -: ADDR_W];
  assign w_timeout    = (r_tcnt == C_TO_LAST);

`ifndef CODEC_INIT_VERIFY_EN
  // Probe read data is never inspected without the read-back check.
  logic w_unused_data_in;
  assign w_unused_data_in = ^codec_data_in;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_retry_state = r_state;
    w_idx_nxt     = r_idx;
    w_retry_nxt   = r_retry;
    w_tcnt_nxt    = r_tcnt;
    w_seen_nxt    = r_seen_busy;
    w_rd_en_nxt   = 1'b0;
    w_wr_en_nxt   = 1'b0;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_alive_nxt   = r_alive;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;
    w_err_idx_nxt = r_err_idx;
    w_fail        = 1'b0;

    case (r_state)
      IDLE: w_state_nxt = PROBE_RD;

      PROBE_RD: begin
        if (!controller_busy) begin
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = w_probe_addr;
          w_tcnt_nxt  = '0;
          w_state_nxt = PROBE_WAIT;
        end
      end

      PROBE_WAIT: begin
        if (codec_data_in_valid) begin
          w_alive_nxt = 1'b1;
          w_idx_nxt   = '0;
          w_retry_nxt = '0;
          w_state_nxt = WR_ISSUE;
        end else if (w_timeout) begin
          w_fail        = 1'b1;
          w_retry_state = PROBE_RD;
        end else begin
          w_tcnt_nxt = r_tcnt + C_TO_W'(1);
        end
      end

      WR_ISSUE: begin
        if (!controller_busy) begin
          w_wr_en_nxt = 1'b1;
          w_addr_nxt  = w_entry_addr;
          w_data_nxt  = w_entry_data;
          w_tcnt_nxt  = '0;
          w_seen_nxt  = 1'b0;
          w_state_nxt = WR_WAIT;
        end
      end

      WR_WAIT: begin
        // Completion is a busy high-then-low pair; it outranks a timeout.
        if (r_seen_busy && !controller_busy) begin
`ifdef CODEC_INIT_VERIFY_EN
          w_state_nxt = VRFY_RD;
`else
          w_state_nxt = NEXT;
`endif
        end else if (w_timeout) begin
          w_fail        = 1'b1;
          w_retry_state = WR_ISSUE;
        end else begin
          w_tcnt_nxt = r_tcnt + C_TO_W'(1);
          if (controller_busy) begin
            w_seen_nxt = 1'b1;
          end
        end
      end

`ifdef CODEC_INIT_VERIFY_EN
      VRFY_RD: begin
        if (!controller_busy) begin
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = w_entry_addr;
          w_tcnt_nxt  = '0;
          w_state_nxt = VRFY_WAIT;
        end
      end

      VRFY_WAIT: begin
        if (codec_data_in_valid) begin
          if (codec_data_in == w_entry_data) begin
            w_state_nxt = NEXT;
          end else begin
            w_fail        = 1'b1;
            w_retry_state = WR_ISSUE;
          end
        end else if (w_timeout) begin
          w_fail        = 1'b1;
          w_retry_state = VRFY_RD;
        end else begin
          w_tcnt_nxt = r_tcnt + C_TO_W'(1);
        end
      end
`endif

      NEXT: begin
        w_retry_nxt = '0;
        if (r_idx == C_IDX_LAST) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = r_idx + C_IDX_W'(1);
          w_state_nxt = WR_ISSUE;
        end
      end

      DONE, ERROR: begin
        if (start) begin
          w_alive_nxt   = 1'b0;
          w_done_nxt    = 1'b0;
          w_error_nxt   = 1'b0;
          w_err_idx_nxt = '0;
          w_state_nxt   = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (w_fail) begin
      if (r_retry < C_RTY_MAX) begin
        w_retry_nxt = r_retry + C_RTY_W'(1);
        w_state_nxt = w_retry_state;
      end else begin
        w_error_nxt   = 1'b1;
        w_err_idx_nxt = (r_state == PROBE_WAIT) ? '0 : (C_ERR_W'(r_idx) + C_ERR_W'(1));
        w_state_nxt   = ERROR;
      end
    end

    if (w_state_nxt == DONE || w_state_nxt == ERROR) begin
      w_addr_nxt = '0;
      w_data_nxt = '0;
    end
    w_busy_nxt = !(w_state_nxt == DONE || w_state_nxt == ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_retry     <= '0;
      r_tcnt      <= '0;
      r_seen_busy <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_alive     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_idx   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_retry     <= w_retry_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_seen_busy <= w_seen_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_alive     <= w_alive_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_err_idx   <= w_err_idx_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign codec_rd_en    = r_rd_en;
  assign codec_wr_en    = r_wr_en;
  assign codec_reg_addr = r_addr;
  assign codec_data_out = r_data;
  assign codec_is_alive = r_alive;
  assign init_done      = r_done;
  assign init_error     = r_error;
  assign error_index    = r_err_idx;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_codec_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_codec_init_sequencer
// Brief    : Transaction-level bench with an I2C controller model for
//            codec_init_sequencer (optional CODEC_INIT_VERIFY_EN scenario).
// Revision : 1.0 - initial release
// ============================================================================
module tb_codec_init_sequencer;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int EW = AW + DW;
  localparam int TO = 16;
  localparam int LAT = 3;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    int            cyc;
  } log_t;

  logic clk, reset, start;
  logic [N*EW-1:0] init_table;
  logic codec_rd_en, codec_wr_en;
  logic [AW-1:0] codec_reg_addr;
  logic [DW-1:0] codec_data_out;
  logic [DW-1:0] m_rdata;
  logic m_valid, m_busy, force_busy;
  logic controller_busy;
  logic codec_is_alive, init_done, init_error, busy;
  logic [$clog2(N+1)-1:0] error_index;

  assign controller_busy = force_busy | m_busy;

  codec_init_sequencer #(
    .NUM_ENTRIES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .init_table(init_table),
    .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
    .codec_reg_addr(codec_reg_addr), .codec_data_out(codec_data_out),
    .codec_data_in(m_rdata), .codec_data_in_valid(m_valid),
    .controller_busy(controller_busy), .codec_is_alive(codec_is_alive),
    .init_done(init_done), .init_error(init_error),
    .error_index(error_index), .busy(busy)
  );

  logic [AW-1:0] tab_addr [N] = '{9'h000, 9'h001, 9'h004, 9'h005};
  logic [DW-1:0] tab_data [N] = '{8'h17, 8'h17, 8'h10, 8'h00};

  int   n_pass = 0, n_checks = 0, cyc = 0;
  txn_t exp_q[$];
  log_t log_q[$];

  logic [DW-1:0] regs [512];
  bit            hang_en = 0, probe_dead = 0, corrupt_en = 0;
  logic [AW-1:0] hang_addr = '0, corrupt_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // I2C controller model: busy for LAT cycles per transaction, read data from regs.
  initial begin
    logic m_active, m_is_wr;
    logic [AW-1:0] m_raddr;
    int m_rem;
    m_active = 0; m_is_wr = 0; m_raddr = '0; m_rem = 0;
    m_busy = 0; m_valid = 0; m_rdata = '0;
    for (int i = 0; i < 512; i++) regs[i] = '0;
    forever begin
      @(negedge clk);
      m_valid = 0;
      if (!reset) begin
        m_busy = 0;
        m_active = 0;
      end else if (m_active) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_active = 0;
          if (!m_is_wr) begin
            m_valid = 1;
            if (corrupt_en && m_raddr == corrupt_addr) begin
              m_rdata = '0;
              corrupt_en = 0;
            end else begin
              m_rdata = regs[m_raddr];
            end
          end
        end
      end else if (codec_wr_en) begin
        if (!(hang_en && codec_reg_addr == hang_addr)) begin
          regs[codec_reg_addr] = codec_data_out;
          m_active = 1; m_is_wr = 1; m_rem = LAT; m_busy = 1;
        end
      end else if (codec_rd_en) begin
        if (!probe_dead) begin
          m_active = 1; m_is_wr = 0; m_rem = LAT; m_busy = 1;
          m_raddr = codec_reg_addr;
        end
      end
    end
  end

  // Per-cycle compare against the expected transaction stream and invariants.
  initial begin
    txn_t e;
    logic [AW-1:0] last_addr;
    bit have_last;
    have_last = 0; last_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        have_last = 0;
      end else begin
        chk("rd_wr_exclusive", {31'd0, codec_rd_en & codec_wr_en}, 0);
        chk("done_err_exclusive", {31'd0, init_done & init_error}, 0);
        if (init_done || init_error)
          chk("final_outputs_idle", {busy, codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out}, 0);
        else if (busy && !codec_rd_en && !codec_wr_en && have_last)
          chk("addr_hold", codec_reg_addr, last_addr);
        if (codec_rd_en || codec_wr_en) begin
          log_q.push_back('{codec_wr_en, codec_reg_addr, cyc});
          last_addr = codec_reg_addr;
          have_last = 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {codec_wr_en, codec_reg_addr}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {31'd0, codec_wr_en}, {31'd0, e.is_wr});
            chk("pulse_addr", codec_reg_addr, e.addr);
            if (codec_wr_en) chk("pulse_data", codec_data_out, e.data);
          end
        end
        if (init_done || init_error) have_last = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_probe(input int tries);
    repeat (tries) exp_q.push_back('{1'b0, tab_addr[0], 8'h00});
  endtask

  task automatic push_entry(input int k);
    exp_q.push_back('{1'b1, tab_addr[k], tab_data[k]});
`ifdef CODEC_INIT_VERIFY_EN
    exp_q.push_back('{1'b0, tab_addr[k], 8'h00});
`endif
  endtask

  task automatic push_full();
    push_probe(1);
    for (int k = 0; k < N; k++) push_entry(k);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(init_done || init_error) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished"}, {31'd0, init_done | init_error}, 1);
    chk({name, "_all_txns_seen"}, exp_q.size(), 0);
  endtask

  task automatic count_pulses(input string name, input bit is_wr, input logic [AW-1:0] a,
                              input int n_exp, input bit gap_chk);
    int c[$];
    foreach (log_q[i]) if (log_q[i].is_wr == is_wr && log_q[i].addr == a) c.push_back(log_q[i].cyc);
    chk({name, "_count"}, c.size(), n_exp);
    if (gap_chk) for (int i = 1; i < c.size(); i++) chk({name, "_gap"}, c[i] - c[i-1], TO);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic hold_reset();
    reset = 0;
    tick(3);
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit saw;
    int n;
    reset = 0; start = 0; force_busy = 1;
    for (int k = 0; k < N; k++) init_table[k*EW +: EW] = {tab_addr[k], tab_data[k]};
    tick(3);
    chk("reset_outputs", {codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out,
                          codec_is_alive, init_done, init_error, error_index, busy}, 0);

    // Nominal sequence with busy held for 50 cycles after reset.
    push_full();
    reset = 1;
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (codec_rd_en) saw = 1;
    end
    chk("bp_no_rd_while_busy", {31'd0, saw}, 0);
    chk("bp_busy_flag", {31'd0, busy}, 1);
    force_busy = 0;
    @(negedge clk);
    chk("bp_rd_one_cycle_after", {31'd0, codec_rd_en}, 1);
    wait_end("nominal");
    chk("nominal_flags", {codec_is_alive, init_done, init_error}, 3'b110);
    chk("nominal_reg4", regs[9'h004], 8'h10);

    // Restart from DONE.
    push_full();
    pulse_start();
    chk("restart_cleared", {codec_is_alive, init_done, init_error, busy}, 4'b0001);
    @(negedge clk);
    chk("restart_no_rd_yet", {31'd0, codec_rd_en}, 0);
    @(negedge clk);
    chk("restart_rd_timing", {31'd0, codec_rd_en}, 1);
    wait_end("restart");
    chk("restart_flags", {codec_is_alive, init_done, init_error}, 3'b110);

    // Reset during WR_WAIT of entry 1.
    push_probe(1); push_entry(0);
    exp_q.push_back('{1'b1, tab_addr[1], tab_data[1]});
    pulse_start();
    n = 0;
    while (!(codec_wr_en && codec_reg_addr == tab_addr[1]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_entry1_write_seen", {31'd0, codec_wr_en}, 1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("mid_reset_outputs", {codec_rd_en, codec_wr_en, codec_reg_addr, codec_data_out,
                              codec_is_alive, init_done, init_error, error_index, busy}, 0);
    @(negedge clk);
    exp_q.delete();
    push_full();
    reset = 1;
    @(negedge clk);
    chk("post_reset_no_rd", {31'd0, codec_rd_en}, 0);
    @(negedge clk);
    chk("post_reset_rd_timing", {31'd0, codec_rd_en}, 1);
    pulse_start();
    wait_end("after_reset");
    chk("after_reset_flags", {codec_is_alive, init_done, init_error}, 3'b110);

    // Write timeout: entry 2 never completes.
    hold_reset();
    hang_en = 1; hang_addr = tab_addr[2];
    push_probe(1); push_entry(0); push_entry(1);
    repeat (3) exp_q.push_back('{1'b1, tab_addr[2], tab_data[2]});
    reset = 1;
    wait_end("wr_timeout");
    chk("wr_timeout_flags", {codec_is_alive, init_done, init_error}, 3'b101);
    chk("wr_timeout_index", error_index, 3);
    count_pulses("wr_timeout_pulses", 1'b1, tab_addr[2], 3, 1'b1);

    // Probe timeout, then recovery via start from ERROR.
    hold_reset();
    hang_en = 0; probe_dead = 1;
    push_probe(3);
    reset = 1;
    wait_end("probe_timeout");
    chk("probe_timeout_flags", {codec_is_alive, init_done, init_error}, 3'b001);
    chk("probe_timeout_index", error_index, 0);
    count_pulses("probe_pulses", 1'b0, tab_addr[0], 3, 1'b1);
    probe_dead = 0;
    push_full();
    pulse_start();
    chk("error_cleared", {init_error, busy}, 2'b01);
    wait_end("recovered");
    chk("recovered_flags", {codec_is_alive, init_done, init_error}, 3'b110);

`ifdef CODEC_INIT_VERIFY_EN
    // Read-back mismatch on entry 1 consumes one retry.
    hold_reset();
    corrupt_en = 1; corrupt_addr = tab_addr[1];
    push_probe(1); push_entry(0); push_entry(1); push_entry(1); push_entry(2); push_entry(3);
    reset = 1;
    wait_end("verify");
    chk("verify_flags", {codec_is_alive, init_done, init_error}, 3'b110);
    count_pulses("verify_wr1", 1'b1, tab_addr[1], 2, 1'b0);
    count_pulses("verify_rd1", 1'b0, tab_addr[1], 2, 1'b0);
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
